tile_write_sched: RTL
=====================

# tile_write_sched

Write scheduler for the 80x30 text screen. It accepts 7-bit character/control codes from two independent requesters, the host CPU port and the keyboard port, and buffers each in its own small FIFO. It arbitrates round-robin and issues single-cycle `tile_mem_wen`/`tile_mem_din` writes to the text screen generator. No write is issued while the generator's screen-clear is in progress (`super_busy`), and a guard gap after every write lets a clear triggered by that write become visible before the next one.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entries per requester FIFO. Power of two, at least 2.
- `GAP_CYCLES`, default 1: idle cycles after each issued write. At least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `host_valid`  in  1  host code valid.
- `host_data`  in  7  host character/control code.
- `host_ready`  out  1  host FIFO not full.
- `kbd_valid`  in  1  keyboard code valid.
- `kbd_data`  in  7  keyboard character/control code.
- `kbd_ready`  out  1  keyboard FIFO not full.
- `super_busy`  in  1  generator clear in progress (includes its start pulse).
- `tile_mem_wen`  out  1  write strobe to generator, one cycle per code.
- `tile_mem_din`  out  7  code presented with `tile_mem_wen`.
- `grant_src`  out  1  source of last issued write: 0 = host, 1 = kbd.
- `sched_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
Requester side:
- A push occurs when `x_valid & x_ready`.
- `x_ready = !full`, combinational from FIFO state only.
- A push and a pop in the same cycle are legal on a non-full, non-empty FIFO. The occupancy does not change.
- Codes are passed through unmodified. ENTER (0x0A), BACKSPACE (0x08) and printable codes are all just data here.

FSM states: IDLE, ISSUE, GAP, CLR_WAIT.
- IDLE, `super_busy`=0 and at least one FIFO non-empty: grant a source, pop its head into the `tile_mem_din` register, go to ISSUE.
- IDLE, `super_busy`=1 or both FIFOs empty: stay in IDLE.
- ISSUE: `tile_mem_wen`=1 for exactly this cycle. Go to GAP and load the gap counter with `GAP_CYCLES`-1.
- GAP: count down. At zero, go to CLR_WAIT if `super_busy`=1, else go to IDLE.
- CLR_WAIT: stay while `super_busy`=1. Go to IDLE in the cycle after it is seen low.

Arbitration:
- If only one FIFO is non-empty, grant it.
- If both are non-empty, grant the source not equal to `grant_src`.
- `grant_src` updates on grant.

Other rules:
- `tile_mem_wen` and `tile_mem_din` are registered outputs. They have no combinational path from `super_busy`, which avoids a loop through the generator's start logic.
- `tile_mem_din` holds its last value outside ISSUE.
- Writing while the generator clears corrupts the tile RAM, so `tile_mem_wen` is never asserted in any cycle where the FSM entered ISSUE with `super_busy` high.

## Timing
Reset values (first cycle after `reset_n` sampled low):
- `tile_mem_wen`=0, `tile_mem_din`=0, `sched_busy`=0.
- `grant_src`=1, so the host wins the first tie.
- State IDLE, both FIFOs empty, so `host_ready` and `kbd_ready` are 1.

Latency: push sampled at edge N, idle scheduler, `super_busy`=0. The pop happens at edge N+1 and `tile_mem_wen` is high in cycle N+1..N+2, i.e. 2 cycles after the push.

Throughput: one write per 2+`GAP_CYCLES` cycles, 3 at the default.

Boundary conditions:
- Full FIFO: ready=0 and a pushed `valid` is ignored. Ready returns in the cycle after a pop.
- `super_busy` rising during GAP: go to CLR_WAIT. The next write comes at least 2 cycles after it falls.
- Reset mid-operation: FIFOs are flushed and in-flight codes are discarded. Reset values apply at the next edge, and no partial write is issued.
- Pointer wrap: FIFO pointers are log2(`FIFO_DEPTH`)+1 bits. Full and empty are distinguished by the MSB.

## Structure
Package `text_sched_pkg` holds:
- the state enum;
- `SRC_HOST`=0 and `SRC_KBD`=1;
- `CODE_W`=7, `KEY_ENTER`=7'h0A, `KEY_BACKSPACE`=7'h08, shared with the generator and the benches.

Sub-module `char_fifo` (parameters `DEPTH`, `W`) has push/pop/full/empty/head and is instantiated twice. The arbiter and FSM live in the top.

## Test plan
- Single host push of 0x41, idle, `super_busy`=0 -> `tile_mem_wen` pulses once 2 cycles later with `tile_mem_din`=0x41 and `grant_src`=0.
- Both FIFOs preloaded, host with 0x41,0x42 and kbd with 0x61,0x62 -> write order 0x41,0x61,0x42,0x62, with writes exactly 3 cycles apart.
- Hold `super_busy`=1, push 3 codes -> no `tile_mem_wen`. Drop `super_busy` -> the 3 writes follow in order, the first 2 cycles later.
- Push 5 codes back-to-back into the kbd FIFO with `super_busy`=1 -> `kbd_ready` falls after the 4th. The 5th is held and accepted after the first write.
- Raise `super_busy` in the GAP after writing 0x0A, hold 10 cycles -> FSM in CLR_WAIT with `sched_busy`=1. The next write comes no earlier than 2 cycles after the fall.
- Assert `reset_n`=0 during ISSUE with both FIFOs non-empty -> next cycle `tile_mem_wen`=0, both readies 1, no further writes after release.

Source files
------------

// File: rtl/text_sched_pkg.sv
// Shared types and constants for the text-screen write path.
// Ports: none (package). Holds the scheduler state enum, source ids and
// code constants used by the scheduler, the generator and the benches.
package text_sched_pkg;

  localparam int CODE_W = 7;

  localparam logic [CODE_W-1:0] KEY_ENTER     = 7'h0A;
  localparam logic [CODE_W-1:0] KEY_BACKSPACE = 7'h08;

  localparam logic SRC_HOST = 1'b0;
  localparam logic SRC_KBD  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_GAP      = 2'd2,
    ST_CLR_WAIT = 2'd3
  } sched_state_t;

endpackage

// File: rtl/char_fifo.sv
// Small synchronous FIFO holding character codes for one requester.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: full blocks further pushes; pop on empty is ignored.
// Ports: clk, reset_n (sync, active-low, flushes), push/din, pop, full,
// empty, head (current oldest entry, valid when !empty).
module char_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 7
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit separates full (MSBs differ) from empty (equal).
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (reset_n && do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tile_write_sched.sv
// Round-robin write scheduler from host/keyboard code FIFOs to the text tile RAM.
// Latency: push at edge N -> tile_mem_wen high in cycle N+1..N+2; one write per 2+GAP_CYCLES.
// Backpressure: x_ready = FIFO not full; no write starts while super_busy is high.
// Ports: clk, reset_n; host_valid/host_data/host_ready; kbd_valid/kbd_data/kbd_ready;
// super_busy (generator clear); tile_mem_wen/tile_mem_din (registered write);
// grant_src (source of last write); sched_busy (FSM not idle).
module tile_write_sched
  import text_sched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              host_valid,
  input  logic [CODE_W-1:0] host_data,
  output logic              host_ready,
  input  logic              kbd_valid,
  input  logic [CODE_W-1:0] kbd_data,
  output logic              kbd_ready,
  input  logic              super_busy,
  output logic              tile_mem_wen,
  output logic [CODE_W-1:0] tile_mem_din,
  output logic              grant_src,
  output logic              sched_busy
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  sched_state_t      state;
  sched_state_t      state_nx;
  logic [GW-1:0]     gap_cnt;

  logic              host_full;
  logic              host_empty;
  logic [CODE_W-1:0] host_head;
  logic              kbd_full;
  logic              kbd_empty;
  logic [CODE_W-1:0] kbd_head;

  logic              grant_vld;
  logic              grant_kbd;
  logic              take;
  logic              host_pop;
  logic              kbd_pop;

  assign host_ready = ~host_full;
  assign kbd_ready  = ~kbd_full;
  assign sched_busy = (state != ST_IDLE);

  char_fifo #(.DEPTH(FIFO_DEPTH), .W(CODE_W)) u_host_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (host_valid & host_ready),
    .din     (host_data),
    .pop     (host_pop),
    .full    (host_full),
    .empty   (host_empty),
    .head    (host_head)
  );

  char_fifo #(.DEPTH(FIFO_DEPTH), .W(CODE_W)) u_kbd_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (kbd_valid & kbd_ready),
    .din     (kbd_data),
    .pop     (kbd_pop),
    .full    (kbd_full),
    .empty   (kbd_empty),
    .head    (kbd_head)
  );

  // Round-robin: on a tie, the source that did not win last time gets it.
  assign grant_vld = ~host_empty | ~kbd_empty;
  assign grant_kbd = (~host_empty & ~kbd_empty) ? (grant_src == SRC_HOST) : ~kbd_empty;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:     if (!super_busy && grant_vld) state_nx = ST_ISSUE;
      ST_ISSUE:    state_nx = ST_GAP;
      ST_GAP:      if (gap_cnt == '0) state_nx = super_busy ? ST_CLR_WAIT : ST_IDLE;
      ST_CLR_WAIT: if (!super_busy) state_nx = ST_IDLE;
      default:     state_nx = ST_IDLE;
    endcase
  end

  // Output decode: a grant is taken exactly on the IDLE -> ISSUE transition.
  always_comb begin
    take     = (state == ST_IDLE) && (state_nx == ST_ISSUE);
    host_pop = take & ~grant_kbd;
    kbd_pop  = take & grant_kbd;
  end

  // The write strobe is registered from the transition decision, so it is
  // high for the whole ISSUE cycle without any path from super_busy to the
  // output pins during that cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tile_mem_wen <= 1'b0;
      tile_mem_din <= '0;
      grant_src    <= SRC_KBD;
      gap_cnt      <= '0;
    end else begin
      tile_mem_wen <= take;
      if (take) begin
        tile_mem_din <= grant_kbd ? kbd_head : host_head;
        grant_src    <= grant_kbd;
      end
      if (state == ST_ISSUE)
        gap_cnt <= GW'(GAP_CYCLES - 1);
      else if ((state == ST_GAP) && (gap_cnt != '0))
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

endmodule
